uart_tx_buffered: RTL and testbench

Buffered UART transmitter for the RV32I SoC, the transmit-side counterpart of the peripheral UART receiver. The core pushes bytes through a memory-mapped write strobe into a small FIFO. A bit-serial state machine drains the FIFO onto the `UART_tx` pin as 8N1 frames, or 8E1 frames when parity is compiled in. Status outputs feed the UART status register, and the FSM state is exported for testbench synchronisation.

---
 rtl/uart_tx_buffered_if.sv | 35 +++
 rtl/uart_tx_buffered.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if
//   Write/status bus between the core (master) and the buffered UART
//   transmitter (slave).
//   tx_data     [7:0] byte to enqueue, sampled on the edge where tx_wr is high
//   tx_wr             one-cycle write strobe
//   tx_full           FIFO holds FIFO_DEPTH entries
//   tx_empty          FIFO holds no entries
//   tx_busy           transmitter active or bytes still queued
//   tx_overflow       one-cycle pulse when a write is dropped
interface uart_tx_buffered_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_empty;
  logic       tx_busy;
  logic       tx_overflow;

  modport master (
    output tx_data,
    output tx_wr,
    input  tx_full,
    input  tx_empty,
    input  tx_busy,
    input  tx_overflow
  );

  modport slave (
    input  tx_data,
    input  tx_wr,
    output tx_full,
    output tx_empty,
    output tx_busy,
    output tx_overflow
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered
//   Buffered UART transmitter. Bytes written over the bus are queued in a
//   small circular FIFO and drained bit-serially onto UART_tx as 8N1 frames,
//   or 8E1 frames when UART_TX_PARITY_EN is defined.
//
// Optional feature macro: UART_TX_PARITY_EN (even parity bit after the data).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_DEPTH    byte entries, power of two, 2..16
//
// Ports
//   clk           system clock
//   rst           asynchronous active-high reset
//   bus           uart_tx_buffered_if.slave (tx_data/tx_wr in, status out)
//   tx_state_out  current FSM state (IDLE=0 START=1 DATA_BITS=2 PARITY=3 STOP=4)
//   UART_tx       registered serial line, idles high
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_buffered_if.slave   bus,
  output logic [2:0]          tx_state_out,
  output logic                UART_tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks.
  generate
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_tx_buffered: CLKS_PER_BIT out of range");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_buffered: FIFO_DEPTH must be a power of two in 2..16");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA_BITS = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4
  } state_t;

  // FSM / datapath registers
  state_t           state_q,   state_d;
  logic [15:0]      baud_q,    baud_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q,   shift_d;
  logic             line_q,    line_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q,  parity_d;
`endif

  // FIFO registers
  logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0] count_q,   count_d;
  logic [7:0]       fifo_mem [FIFO_DEPTH];

  logic [7:0]       fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             baud_done;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign baud_done  = (baud_q == BAUD_LAST);

  // A dequeue in the same cycle frees a slot, so a write to a full FIFO is
  // still accepted when the FSM pops at that edge.
  assign push = bus.tx_wr && (!fifo_full || pop);

  assign bus.tx_full     = fifo_full;
  assign bus.tx_empty    = fifo_empty;
  assign bus.tx_busy     = (state_q != IDLE) || !fifo_empty;
  assign bus.tx_overflow = bus.tx_wr && fifo_full && !pop;

  assign UART_tx      = line_q;
  assign tx_state_out = state_q;

  // Storage is left unreset: after reset the pointers and count mark it empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= bus.tx_data;
    end
  end

  // FIFO pointer and occupancy update.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM next-state logic. line_d carries the level of the state
  // being entered so UART_tx changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    line_d    = line_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        baud_d = 16'd0;
        line_d = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^fifo_head;
`endif
          state_d   = START;
          line_d    = 1'b0;
        end
      end

      START: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          state_d = DATA_BITS;
          line_d  = shift_q[0];
        end
      end

      DATA_BITS: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
            line_d    = parity_q;
`else
            state_d   = STOP;
            line_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            line_d    = shift_q[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          baud_d  = 16'd0;
          state_d = STOP;
          line_d  = 1'b1;
        end
      end
`endif

      STOP: begin
        if (baud_done) begin
          baud_d = 16'd0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit: frames are contiguous.
            pop       = 1'b1;
            shift_d   = fifo_head;
            bit_cnt_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            parity_d  = ^fifo_head;
`endif
            state_d   = START;
            line_d    = 1'b0;
          end else begin
            state_d = IDLE;
            line_d  = 1'b1;
          end
        end
      end

      default: begin
        baud_d  = 16'd0;
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  // All state registers. Asynchronous reset drives the line high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= 16'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      line_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      line_q    <= line_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered
//   Directed bench for uart_tx_buffered with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   Follows UART_TX_PARITY_EN for frame length and parity expectations.
module tb_uart_tx_buffered;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk;
  logic       rst;
  logic [2:0] tx_state_out;
  logic       UART_tx;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .tx_state_out (tx_state_out),
    .UART_tx      (UART_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line levels of one frame, index 0 = start bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = 11'h7FF;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // ---------------- Cycle counter and line receiver ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_bytes[$];
  int         rx_start[$];
  int         rx_err = 0;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  int         rx_start_cyc = 0;
  logic [7:0] rx_sh = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (UART_tx == 1'b0) begin
        rx_active    = 1'b1;
        rx_cnt       = 0;
        rx_start_cyc = cyc;
        rx_sh        = 8'h00;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % C) == C / 2) begin
        int k;
        k = rx_cnt / C;
        if (k == 0) begin
          if (UART_tx !== 1'b0) rx_err++;
        end else if (k <= 8) begin
          rx_sh[k-1] = UART_tx;
        end else if (k == NBITS - 1) begin
          if (UART_tx !== 1'b1) rx_err++;
          rx_bytes.push_back(rx_sh);
          rx_start.push_back(rx_start_cyc);
          rx_active = 1'b0;
        end else begin
          if (UART_tx !== ^rx_sh) rx_err++;
        end
      end
    end
  end

  // ---------------- Helpers ----------------
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (bus.tx_busy && n < budget) begin
      step();
      n++;
    end
    chk("idle_reached", bus.tx_busy, 1'b0);
  endtask

  // Single write into an idle transmitter, then a cycle-exact frame check.
  task automatic send_check(input logic [7:0] b);
    logic [10:0] bits;
    logic [3:0]  pat;
    logic        busy_last;
    int          base;
    base        = rx_bytes.size();
    bits        = frame_bits(b);
    busy_last   = 1'b0;
    bus.tx_data = b;
    bus.tx_wr   = 1'b1;
    step();
    bus.tx_wr   = 1'b0;
    chk("empty_after_wr", bus.tx_empty, 1'b0);
    chk("busy_after_wr", bus.tx_busy, 1'b1);
    chk("line_high_after_wr", UART_tx, 1'b1);
    step();
    chk("state_start", tx_state_out, 3'd1);
    chk("empty_after_pop", bus.tx_empty, 1'b1);
    for (int k = 0; k < NBITS; k++) begin
      pat = 4'h0;
      for (int c = 0; c < C; c++) begin
        pat[c] = UART_tx;
        if (k == NBITS - 1 && c == C - 1) busy_last = bus.tx_busy;
        step();
      end
      chk($sformatf("byte%02h_bit%0d", b, k), pat, bits[k] ? 4'hF : 4'h0);
    end
    chk("busy_last_frame_cycle", busy_last, 1'b1);
    chk("busy_after_frame", bus.tx_busy, 1'b0);
    chk("state_idle_after_frame", tx_state_out, 3'd0);
    chk("rx_count", rx_bytes.size() - base, 1);
    if (rx_bytes.size() > base) chk("rx_byte", rx_bytes[base], b);
  endtask

  // ---------------- Main sequence ----------------
  initial begin
    int base;
    int bad_line, bad_empty, bad_busy, ov_seen, low_cnt;

    rst         = 1'b1;
    bus.tx_wr   = 1'b0;
    bus.tx_data = 8'h00;
    step();
    step();

    // Reset values
    chk("rst_line", UART_tx, 1'b1);
    chk("rst_state", tx_state_out, 3'd0);
    chk("rst_full", bus.tx_full, 1'b0);
    chk("rst_empty", bus.tx_empty, 1'b1);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_overflow", bus.tx_overflow, 1'b0);

    rst = 1'b0;
    bad_line = 0; bad_empty = 0; bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (UART_tx !== 1'b1) bad_line++;
      if (bus.tx_empty !== 1'b1) bad_empty++;
      if (bus.tx_busy !== 1'b0) bad_busy++;
    end
    chk("idle20_line_bad", bad_line, 0);
    chk("idle20_empty_bad", bad_empty, 0);
    chk("idle20_busy_bad", bad_busy, 0);

    // Single frames
    send_check(8'h55);
    send_check(8'h07);

    // Back-to-back writes
    base = rx_bytes.size();
    bus.tx_wr = 1'b1;
    bus.tx_data = 8'hA3; step();
    bus.tx_data = 8'h00; step();
    bus.tx_data = 8'hFF; step();
    bus.tx_wr = 1'b0;
    wait_idle(3 * NBITS * C + 40);
    chk("b2b_rx_count", rx_bytes.size() - base, 3);
    if (rx_bytes.size() >= base + 3) begin
      chk("b2b_byte0", rx_bytes[base],   8'hA3);
      chk("b2b_byte1", rx_bytes[base+1], 8'h00);
      chk("b2b_byte2", rx_bytes[base+2], 8'hFF);
      chk("b2b_gap01", rx_start[base+1] - rx_start[base],   NBITS * C);
      chk("b2b_gap12", rx_start[base+2] - rx_start[base+1], NBITS * C);
    end

    // Overflow
    base = rx_bytes.size();
    ov_seen = 0;
    for (int i = 0; i < 5; i++) begin
      bus.tx_data = 8'h10 + 8'(i);
      bus.tx_wr   = 1'b1;
      #1;
      if (bus.tx_overflow !== 1'b0) ov_seen++;
      step();
    end
    chk("ovf_accepted_no_pulse", ov_seen, 0);
    bus.tx_data = 8'h15;
    #1;
    chk("ovf_full", bus.tx_full, 1'b1);
    chk("ovf_pulse", bus.tx_overflow, 1'b1);
    step();
    bus.tx_wr = 1'b0;
    #1;
    chk("ovf_pulse_end", bus.tx_overflow, 1'b0);
    chk("ovf_still_full", bus.tx_full, 1'b1);
    wait_idle(5 * NBITS * C + 40);
    chk("ovf_rx_count", rx_bytes.size() - base, 5);
    if (rx_bytes.size() >= base + 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("ovf_byte%0d", i), rx_bytes[base+i], 8'h10 + 8'(i));
      end
    end

    // Reset during DATA_BITS bit 3 of 0xA5 (bit 3 is 0, so the line is low)
    base = rx_bytes.size();
    bus.tx_wr = 1'b1;
    bus.tx_data = 8'hA5; step();
    bus.tx_data = 8'h11; step();
    bus.tx_data = 8'h22; step();
    bus.tx_wr = 1'b0;
    repeat (16) step();
    chk("mid_state_data", tx_state_out, 3'd2);
    chk("mid_line_bit3", UART_tx, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_line", UART_tx, 1'b1);
    chk("async_rst_state", tx_state_out, 3'd0);
    chk("async_rst_empty", bus.tx_empty, 1'b1);
    step();
    step();
    rst = 1'b0;
    low_cnt = 0;
    bad_busy = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (UART_tx !== 1'b1) low_cnt++;
      if (bus.tx_busy !== 1'b0) bad_busy++;
    end
    chk("post_rst_line_low_cycles", low_cnt, 0);
    chk("post_rst_busy_cycles", bad_busy, 0);
    chk("post_rst_empty", bus.tx_empty, 1'b1);
    chk("post_rst_rx_count", rx_bytes.size() - base, 0);

    chk("rx_frame_errors", rx_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d expected=done", cyc);
    $fatal(1, "timeout");
  end

endmodule
